// File: rtl/usr_serial_deser_if.sv
// Receive-side bundle of the serial link: the serial input, control strobes
// and the parallel valid/ready output of the deserializer.
interface usr_serial_deser_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             sdi;
  logic             sdi_en;
  logic             dir;
  logic             clr;
  logic [WIDTH-1:0] pdo;
  logic             pdo_valid;
  logic             pdo_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output sdi, sdi_en, dir, clr, pdo_ready,
    input  pdo, pdo_valid, overrun, bit_cnt
  );

  modport slave (
    input  sdi, sdi_en, dir, clr, pdo_ready,
    output pdo, pdo_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/usr_serial_deser.sv
// Serial-to-parallel receiver: collects WIDTH strobed bits in either order
// into a one-entry valid/ready output buffer with a sticky overrun flag.
module usr_serial_deser #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  usr_serial_deser_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} phase_t;

  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dir_q_reg, dir_q_next;
  logic [WIDTH-1:0] pdo_reg, pdo_next;
  logic             valid_reg, valid_next;
  logic             ovr_reg, ovr_next;

  phase_t           phase;
  logic             ord;
  logic             complete;
  logic             drain;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg    <= '0;
      cnt_reg   <= '0;
      dir_q_reg <= 1'b0;
      pdo_reg   <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
      dir_q_reg <= dir_q_next;
      pdo_reg   <= pdo_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    phase      = (cnt_reg == '0) ? IDLE : SHIFT;
    // The first bit of a word takes its order straight from dir.
    ord        = (phase == IDLE) ? bus.dir : dir_q_reg;
    shifted    = ord ? {bus.sdi, sh_reg[WIDTH-1:1]} : {sh_reg[WIDTH-2:0], bus.sdi};
    drain      = valid_reg && bus.pdo_ready;
    complete   = 1'b0;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    dir_q_next = dir_q_reg;
    pdo_next   = pdo_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;

    if (bus.clr) begin
      sh_next  = '0;
      cnt_next = '0;
      ovr_next = 1'b0;
    end else if (bus.sdi_en) begin
      if (phase == IDLE) dir_q_next = bus.dir;
      sh_next = shifted;
      if (cnt_reg == LAST) begin
        cnt_next = '0;
        complete = 1'b1;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end

    // A buffer being drained this cycle counts as free for the new word.
    if (complete) begin
      if (!valid_reg || drain) begin
        pdo_next   = shifted;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end else if (drain) begin
      valid_next = 1'b0;
    end
  end

  always_comb begin
    bus.pdo       = pdo_reg;
    bus.pdo_valid = valid_reg;
    bus.overrun   = ovr_reg;
    bus.bit_cnt   = cnt_reg;
  end
endmodule
